branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Branch-decision block of the CPU datapath.
- Combines the current 3-bit opcode, the ALU zero/carry flags and the control-unit jump strobe to decide whether the PC loads the branch target.
- Decision is combinational, same cycle.
- Also provides a one-cycle registered copy of the decision for the pipeline/PC-load stage, plus optional branch statistics counters.

Parameters:
- OP_JMP, 3'b100, unconditional jump opcode
- OP_JZ, 3'b101, jump-if-zero opcode
- OP_JC, 3'b110, jump-if-carry opcode
- CNT_W, 16, width of statistics counters (only used with BRANCH_STATS_EN)

Ports:
- clk_i  input  1  system clock, rising edge
- rst_n_i  input  1  synchronous reset, active-low
- op_i  input  3  opcode of current instruction
- flag_z_i  input  1  ALU zero flag
- flag_c_i  input  1  ALU carry flag
- ctrl_jmp_i  input  1  control-unit jump-evaluate strobe
- branch_o  output  1  combinational branch-taken decision
- branch_q_o  output  1  branch_o registered one cycle
- taken_cnt_o  output  CNT_W  number of taken branches (stats)
- eval_cnt_o  output  CNT_W  number of evaluated branch opcodes (stats)

Behaviour:
- branch_o = ctrl_jmp_i & ((op_i==OP_JMP) | (op_i==OP_JZ & flag_z_i) | (op_i==OP_JC & flag_c_i)).
- branch_o is purely combinational, zero latency, and not gated by reset or clock. It is valid within the same delta as input changes, with no clock running.
- All other opcodes (000-011, 111) never branch, regardless of flags or ctrl_jmp_i.
- ctrl_jmp_i=0 forces branch_o=0 for every opcode and flag combination.
- JMP ignores both flags. JZ ignores flag_c_i. JC ignores flag_z_i.
- branch_q_o: on each rising clk_i, branch_q_o <= branch_o. If rst_n_i=0 at the edge, branch_q_o <= 0.
- Reset value of branch_q_o = 0. Asserting reset mid-operation clears branch_q_o on the next edge; branch_o is unaffected.
- No X-propagation masking: unknown inputs yield unknown branch_o.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - eval_cnt_o increments on each rising edge where ctrl_jmp_i=1 and op_i is OP_JMP, OP_JZ or OP_JC.
  - taken_cnt_o increments on each rising edge where branch_o=1.
  - Both counters saturate at all-ones; no wrap.
  - Both counters reset to 0 when rst_n_i=0 at an edge; reset has priority over increment.
  - taken_cnt_o never exceeds eval_cnt_o.
- Undefined: taken_cnt_o and eval_cnt_o are tied to 0, no counter flops are present, and the port list is unchanged.

Test Plan:
- op=100, z=0, c=0, jmp=1 -> branch_o=1. Same with jmp=0 -> branch_o=0.
- op=010 (LDA), z=0, c=0, jmp=1 -> branch_o=0. Sweep all non-branch opcodes with all flags -> always 0.
- op=101, z=1, c=0, jmp=1 -> 1. Same with jmp=0 -> 0. op=101, z=0, c=1, jmp=1 -> 0.
- op=110, z=0, c=1, jmp=1 -> 1. op=110, z=0, c=0, jmp=1 -> 0. op=110, z=1, c=0, jmp=1 -> 0.
- Clocked: hold rst_n_i=0 for 2 edges -> branch_q_o=0. Release, drive JMP with jmp=1 -> branch_q_o=1 one edge later. Assert rst_n_i=0 while branch_o=1 -> branch_q_o=0 after the edge.
- With BRANCH_STATS_EN:
  - Apply 3 edges of JMP/jmp=1 -> eval_cnt_o=3, taken_cnt_o=3.
  - Then 2 edges of JC, c=0, jmp=1 -> eval_cnt_o=5, taken_cnt_o=3.
  - Then reset -> both 0.
  - With CNT_W=2, 5 taken branches -> taken_cnt_o=3 (saturated).

Source files
------------

// File: rtl/branch_unit.sv
// Branch decision for the CPU datapath: combinational taken flag, registered copy,
// and optional saturating branch statistics enabled by defining BRANCH_STATS_EN.
module branch_unit #(
    parameter logic [2:0] OP_JMP = 3'b100,
    parameter logic [2:0] OP_JZ  = 3'b101,
    parameter logic [2:0] OP_JC  = 3'b110,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [2:0]       op_i,
    input  logic             flag_z_i,
    input  logic             flag_c_i,
    input  logic             ctrl_jmp_i,
    output logic             branch_o,
    output logic             branch_q_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] eval_cnt_o
);

    // Plain equality/AND so unknown inputs propagate to the decision.
    assign branch_o = ctrl_jmp_i & ((op_i == OP_JMP)
                                  | ((op_i == OP_JZ) & flag_z_i)
                                  | ((op_i == OP_JC) & flag_c_i));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            branch_q_o <= 1'b0;
        end else begin
            branch_q_o <= branch_o;
        end
    end

`ifdef BRANCH_STATS_EN
    logic             is_branch_op;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] eval_cnt;

    assign is_branch_op = (op_i == OP_JMP) | (op_i == OP_JZ) | (op_i == OP_JC);

    // Taken implies evaluated and both saturate at the same ceiling,
    // so taken_cnt can never overtake eval_cnt.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            taken_cnt <= '0;
            eval_cnt  <= '0;
        end else begin
            if (ctrl_jmp_i && is_branch_op && (eval_cnt != '1)) begin
                eval_cnt <= eval_cnt + 1'b1;
            end
            if (branch_o && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

    assign taken_cnt_o = taken_cnt;
    assign eval_cnt_o  = eval_cnt;
`else
    assign taken_cnt_o = '0;
    assign eval_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed decision cases, clocked reset
// behaviour, statistics (default and CNT_W=2 instances), then random traffic.
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op;
    logic        fz;
    logic        fc;
    logic        jmp;
    logic        branch;
    logic        branch_q;
    logic [15:0] taken_cnt;
    logic [15:0] eval_cnt;
    logic        branch2;
    logic        branch_q2;
    logic [1:0]  taken_cnt2;
    logic [1:0]  eval_cnt2;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Reference state: unbounded event counts, clipped to the counter width on compare.
    int m_eval  = 0;
    int m_taken = 0;
    logic m_q   = 1'b0;

    branch_unit dut (
        .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .flag_z_i(fz), .flag_c_i(fc),
        .ctrl_jmp_i(jmp), .branch_o(branch), .branch_q_o(branch_q),
        .taken_cnt_o(taken_cnt), .eval_cnt_o(eval_cnt)
    );

    branch_unit #(.CNT_W(2)) dut_narrow (
        .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .flag_z_i(fz), .flag_c_i(fc),
        .ctrl_jmp_i(jmp), .branch_o(branch2), .branch_q_o(branch_q2),
        .taken_cnt_o(taken_cnt2), .eval_cnt_o(eval_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decision rule written from the opcode table.
    function automatic logic ref_branch(input logic [2:0] o, input logic z, input logic c,
                                        input logic j);
        logic r;
        r = 1'b0;
        if (j) begin
            case (o)
                3'b100:  r = 1'b1;
                3'b101:  r = z;
                3'b110:  r = c;
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic int clip(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return STATS ? ((v > mx) ? mx : v) : 0;
    endfunction

    task automatic drive(input logic [2:0] o, input logic z, input logic c, input logic j,
                         input logic r);
        op = o; fz = z; fc = c; jmp = j; rst_n = r;
    endtask

    // Combinational check: drive right after a falling edge, sample before the next rise.
    task automatic comb_check(input string tag, input logic [2:0] o, input logic z,
                              input logic c, input logic j);
        @(negedge clk);
        drive(o, z, c, j, rst_n);
        #1;
        check(tag, {31'b0, branch}, {31'b0, ref_branch(o, z, c, j)});
    endtask

    // One clocked step: drive, check decision, clock, update model, check state.
    task automatic step(input logic [2:0] o, input logic z, input logic c, input logic j,
                        input logic r);
        logic exp_b;
        @(negedge clk);
        drive(o, z, c, j, r);
        #1;
        exp_b = ref_branch(o, z, c, j);
        check("branch_o", {31'b0, branch}, {31'b0, exp_b});
        @(posedge clk);
        if (!r) begin
            m_q = 1'b0; m_eval = 0; m_taken = 0;
        end else begin
            m_q = exp_b;
            if (j && (o == 3'b100 || o == 3'b101 || o == 3'b110)) m_eval++;
            if (exp_b) m_taken++;
        end
        #1;
        check("branch_q_o", {31'b0, branch_q}, {31'b0, m_q});
        check("eval_cnt", {16'b0, eval_cnt}, clip(m_eval, 16));
        check("taken_cnt", {16'b0, taken_cnt}, clip(m_taken, 16));
        check("eval_cnt_w2", {30'b0, eval_cnt2}, clip(m_eval, 2));
        check("taken_cnt_w2", {30'b0, taken_cnt2}, clip(m_taken, 2));
    endtask

    initial begin
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed decision cases, held in reset so clock edges leave state at zero.
        comb_check("jmp_taken",     3'b100, 0, 0, 1);
        comb_check("jmp_no_strobe", 3'b100, 0, 0, 0);
        comb_check("lda_no_branch", 3'b010, 0, 0, 1);
        comb_check("jz_taken",      3'b101, 1, 0, 1);
        comb_check("jz_no_strobe",  3'b101, 1, 0, 0);
        comb_check("jz_carry_only", 3'b101, 0, 1, 1);
        comb_check("jc_taken",      3'b110, 0, 1, 1);
        comb_check("jc_clear",      3'b110, 0, 0, 1);
        comb_check("jc_zero_only",  3'b110, 1, 0, 1);
        for (int k = 0; k < 8; k++) begin
            for (int f = 0; f < 8; f++) begin
                logic [2:0] kv;
                logic [2:0] fv;
                kv = 3'(k);
                fv = 3'(f);
                if (kv == 3'b100 || kv == 3'b101 || kv == 3'b110) continue;
                comb_check("non_branch_sweep", kv, fv[0], fv[1], fv[2]);
            end
        end

        @(negedge clk);
        drive(3'b100, 1'b0, 1'b0, 1'bx, 1'b0);
        #1;
        check("x_strobe_propagates", {31'b0, branch}, {31'b0, 1'bx});

        // Reset held for two edges, then JMP, then reset while taken.
        step(3'b000, 0, 0, 0, 0);
        step(3'b000, 0, 0, 0, 0);
        check("reset_q", {31'b0, branch_q}, 32'd0);
        step(3'b100, 0, 0, 1, 1);
        check("jmp_q_after_edge", {31'b0, branch_q}, 32'd1);
        step(3'b100, 0, 0, 1, 0);
        check("reset_clears_q", {31'b0, branch_q}, 32'd0);
        check("reset_keeps_branch", {31'b0, branch}, 32'd1);

        // Statistics sequence.
        repeat (3) step(3'b100, 0, 0, 1, 1);
        check("stats_eval_3", {16'b0, eval_cnt}, STATS ? 32'd3 : 32'd0);
        check("stats_taken_3", {16'b0, taken_cnt}, STATS ? 32'd3 : 32'd0);
        repeat (2) step(3'b110, 0, 0, 1, 1);
        check("stats_eval_5", {16'b0, eval_cnt}, STATS ? 32'd5 : 32'd0);
        check("stats_taken_still_3", {16'b0, taken_cnt}, STATS ? 32'd3 : 32'd0);
        step(3'b000, 0, 0, 0, 0);
        check("stats_reset_eval", {16'b0, eval_cnt}, 32'd0);
        check("stats_reset_taken", {16'b0, taken_cnt}, 32'd0);
        repeat (5) step(3'b100, 0, 0, 1, 1);
        check("narrow_taken_saturated", {30'b0, taken_cnt2}, STATS ? 32'd3 : 32'd0);

        // Random traffic, occasional resets, branch opcodes weighted up.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] ro;
            ro = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(4, 6)) : 3'($urandom_range(0, 7));
            step(ro, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 31) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
